// File: rtl/id_ex_stage_if.sv
// ID/EX boundary bundle: decode-side fields in, registered EX-side copies out, plus flush/hold/stall.
// Latency: none here. This is the wiring only. The stage register is in id_ex_stage.
// Backpressure: hold freezes the stage, stall_out freezes PC and IF/ID, and flush squashes the ID slot.
//
// Signals:
//   id_valid, id_pc_plus4, id_rdata1, id_rdata2, id_imm, id_rs, id_rt, id_rd, id_funct,
//   id_RegDst .. id_RegWrite, id_ALUop          : decode-side inputs to the stage
//   flush, hold                                  : squash / freeze requests from downstream
//   ex_* (same set), ex_valid                    : registered EX-side copies
//   stall_out                                    : load-use stall toward PC and IF/ID
// Modports:
//   master : the environment (decode plus downstream).
//   slave  : the ID/EX stage.
interface id_ex_stage_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
);
    logic              id_valid;
    logic [DATA_W-1:0] id_pc_plus4;
    logic [DATA_W-1:0] id_rdata1;
    logic [DATA_W-1:0] id_rdata2;
    logic [DATA_W-1:0] id_imm;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic [REG_AW-1:0] id_rd;
    logic [5:0]        id_funct;
    logic              id_RegDst;
    logic              id_Branch;
    logic              id_MemRead;
    logic              id_MemtoReg;
    logic              id_MemWrite;
    logic              id_ALUsrc;
    logic              id_RegWrite;
    logic [1:0]        id_ALUop;

    logic              flush;
    logic              hold;

    logic              ex_valid;
    logic [DATA_W-1:0] ex_pc_plus4;
    logic [DATA_W-1:0] ex_rdata1;
    logic [DATA_W-1:0] ex_rdata2;
    logic [DATA_W-1:0] ex_imm;
    logic [REG_AW-1:0] ex_rs;
    logic [REG_AW-1:0] ex_rt;
    logic [REG_AW-1:0] ex_rd;
    logic [5:0]        ex_funct;
    logic              ex_RegDst;
    logic              ex_Branch;
    logic              ex_MemRead;
    logic              ex_MemtoReg;
    logic              ex_MemWrite;
    logic              ex_ALUsrc;
    logic              ex_RegWrite;
    logic [1:0]        ex_ALUop;

    logic              stall_out;

    modport master (
        output id_valid, id_pc_plus4, id_rdata1, id_rdata2, id_imm,
               id_rs, id_rt, id_rd, id_funct,
               id_RegDst, id_Branch, id_MemRead, id_MemtoReg,
               id_MemWrite, id_ALUsrc, id_RegWrite, id_ALUop,
               flush, hold,
        input  ex_valid, ex_pc_plus4, ex_rdata1, ex_rdata2, ex_imm,
               ex_rs, ex_rt, ex_rd, ex_funct,
               ex_RegDst, ex_Branch, ex_MemRead, ex_MemtoReg,
               ex_MemWrite, ex_ALUsrc, ex_RegWrite, ex_ALUop,
               stall_out
    );

    modport slave (
        input  id_valid, id_pc_plus4, id_rdata1, id_rdata2, id_imm,
               id_rs, id_rt, id_rd, id_funct,
               id_RegDst, id_Branch, id_MemRead, id_MemtoReg,
               id_MemWrite, id_ALUsrc, id_RegWrite, id_ALUop,
               flush, hold,
        output ex_valid, ex_pc_plus4, ex_rdata1, ex_rdata2, ex_imm,
               ex_rs, ex_rt, ex_rd, ex_funct,
               ex_RegDst, ex_Branch, ex_MemRead, ex_MemtoReg,
               ex_MemWrite, ex_ALUsrc, ex_RegWrite, ex_ALUop,
               stall_out
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion, flush and hold.
// Latency: 1 cycle from ID to EX. stall_out is combinational from the EX state and the ID fields.
// Backpressure: hold freezes every register, and flush overrides hold. A load-use hazard bubbles EX and raises stall_out.
//
// Ports:
//   clk    : rising-edge pipeline clock
//   rst_n  : asynchronous active-low reset. It clears all EX state.
//   bus    : id_ex_stage_if.slave, which carries the id_* inputs, flush, hold, the ex_* outputs and stall_out.
//   bubble_cnt, flush_cnt : 32-bit event counters. They exist only when ID_EX_PERF_CNT_EN is defined.
// Optional feature macro: ID_EX_PERF_CNT_EN
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    id_ex_stage_if.slave bus
`ifdef ID_EX_PERF_CNT_EN
    ,
    output logic [31:0]  bubble_cnt,
    output logic [31:0]  flush_cnt
`endif
);

    // The eight decode control outputs. A bubble or a squash clears them as a group.
    typedef struct packed {
        logic       reg_dst;
        logic       branch;
        logic       mem_read;
        logic       mem_to_reg;
        logic       mem_write;
        logic       alu_src;
        logic       reg_write;
        logic [1:0] alu_op;
    } ctrl_t;

    // The operand, immediate and specifier fields. They never influence EX side effects on their own.
    typedef struct packed {
        logic [DATA_W-1:0] pc_plus4;
        logic [DATA_W-1:0] rdata1;
        logic [DATA_W-1:0] rdata2;
        logic [DATA_W-1:0] imm;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
        logic [REG_AW-1:0] rd;
        logic [5:0]        funct;
    } data_t;

    ctrl_t id_ctrl;
    ctrl_t ex_ctrl;
    ctrl_t ctrl_nxt;
    data_t id_data;
    data_t ex_data;
    data_t data_nxt;
    logic  ex_vld;
    logic  vld_nxt;
    logic  rt_used;
    logic  hz;

    assign id_ctrl = {bus.id_RegDst, bus.id_Branch, bus.id_MemRead, bus.id_MemtoReg,
                      bus.id_MemWrite, bus.id_ALUsrc, bus.id_RegWrite, bus.id_ALUop};

    assign id_data = {bus.id_pc_plus4, bus.id_rdata1, bus.id_rdata2, bus.id_imm,
                      bus.id_rs, bus.id_rt, bus.id_rd, bus.id_funct};

    // ID reads rt for R-format and bne, where ALUsrc = 0, and for sw, where rt is the store data.
    // Loads and immediate ALU ops write rt instead, so a match on rt is no hazard for them.
    assign rt_used = ~bus.id_ALUsrc | bus.id_MemWrite;

    // Load-use hazard. Register 0 is never a real dependency.
    assign hz = ex_vld & ex_ctrl.mem_read & bus.id_valid & (ex_data.rt != '0) &
                ((ex_data.rt == bus.id_rs) | ((ex_data.rt == bus.id_rt) & rt_used));

    // A flushed or held cycle inserts no bubble, so upstream must not freeze for it.
    assign bus.stall_out = hz & ~bus.flush & ~bus.hold;

    always_comb begin
        vld_nxt  = ex_vld;
        ctrl_nxt = ex_ctrl;
        data_nxt = ex_data;
        if (bus.flush) begin
            // The data fields are don't-care when the slot is squashed. Loading ID keeps the mux shallow.
            vld_nxt  = 1'b0;
            ctrl_nxt = '0;
            data_nxt = id_data;
        end else if (!bus.hold) begin
            data_nxt = id_data;
            if (hz || !bus.id_valid) begin
                // A bubble, or an empty ID slot, carries no control into EX.
                vld_nxt  = 1'b0;
                ctrl_nxt = '0;
            end else begin
                vld_nxt  = 1'b1;
                ctrl_nxt = id_ctrl;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_vld  <= 1'b0;
            ex_ctrl <= '0;
            ex_data <= '0;
        end else begin
            ex_vld  <= vld_nxt;
            ex_ctrl <= ctrl_nxt;
            ex_data <= data_nxt;
        end
    end

    assign bus.ex_valid = ex_vld;

    assign {bus.ex_RegDst, bus.ex_Branch, bus.ex_MemRead, bus.ex_MemtoReg,
            bus.ex_MemWrite, bus.ex_ALUsrc, bus.ex_RegWrite, bus.ex_ALUop} = ex_ctrl;

    assign {bus.ex_pc_plus4, bus.ex_rdata1, bus.ex_rdata2, bus.ex_imm,
            bus.ex_rs, bus.ex_rt, bus.ex_rd, bus.ex_funct} = ex_data;

`ifdef ID_EX_PERF_CNT_EN
    logic bubble_evt;
    logic flush_evt;

    // A bubble is counted only when it is actually inserted. Hold or flush suppresses the insertion.
    assign bubble_evt = hz & ~bus.flush & ~bus.hold;
    // A flush is counted only when it squashes a real instruction. It is counted even while hold is high.
    assign flush_evt  = bus.flush & bus.id_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_cnt <= '0;
            flush_cnt  <= '0;
        end else begin
            if (bubble_evt) begin
                bubble_cnt <= bubble_cnt + 32'd1;
            end
            if (flush_evt) begin
                flush_cnt <= flush_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage. It uses a vector table with a scoreboard queue, plus reset and counter sequences.
// Latency: expectations are pushed at drive time and popped one clock edge later.
// Backpressure: the flush, hold and hazard combinations are exercised through the table.
module tb_id_ex_stage;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int DATA_BITS = 4 * DW + 3 * AW + 6;

    // Control order: RegDst Branch MemRead MemtoReg MemWrite ALUsrc RegWrite ALUop[1:0]
    localparam logic [8:0] C_NOP  = 9'b000000000;
    localparam logic [8:0] C_R    = 9'b100000110;
    localparam logic [8:0] C_LW   = 9'b001101100;
    localparam logic [8:0] C_SW   = 9'b000011000;
    localparam logic [8:0] C_BNE  = 9'b010000001;
    localparam logic [8:0] C_ADDI = 9'b000001100;
    localparam logic [8:0] M_ALL  = 9'b111111111;
    localparam logic [8:0] M_SW   = 9'b011011111; // RegDst and MemtoReg are don't-care for sw
    localparam logic [8:0] M_BNE  = 9'b011111111; // RegDst is don't-care for bne

    localparam int N_A   = 27;  // main table: entries 0..26
    localparam int I_PRE = 27;  // loads a lw before the mid-cycle reset
    localparam int N_VEC = 36;  // entries 28..35 follow the reset

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] bubble_cnt;
    logic [31:0] flush_cnt;
`endif

    id_ex_stage_if #(.DATA_W(DW), .REG_AW(AW)) bus ();

    id_ex_stage #(.DATA_W(DW), .REG_AW(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus)
`ifdef ID_EX_PERF_CNT_EN
        ,
        .bubble_cnt (bubble_cnt),
        .flush_cnt  (flush_cnt)
`endif
    );

    typedef struct {
        logic       vld;
        logic [8:0] ctrl;
        logic [4:0] rs, rt, rd;
        logic [7:0] key;
        logic       flush, hold;
        logic       exp_stall;
        logic       exp_vld;
        logic [8:0] exp_ctrl;
        logic [8:0] mask;
        logic       chk_data;
        logic [4:0] exp_rs, exp_rt, exp_rd;
        logic [7:0] exp_key;
    } vec_t;

    typedef struct {
        int                   idx;
        logic                 vld;
        logic [8:0]           ctrl;
        logic [8:0]           mask;
        logic                 chk;
        logic [DATA_BITS-1:0] data;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[N_VEC];
    int   errors = 0;
    int   checks = 0;

    function automatic logic [DATA_BITS-1:0] mk_data(input logic [4:0] rs, input logic [4:0] rt,
                                                     input logic [4:0] rd, input logic [7:0] key);
        logic [31:0] pc4, r1, r2, imm;
        pc4 = {16'h0040, key, 8'h04};
        r1  = {24'h0, key};
        r2  = {key, 24'h0};
        imm = {{24{key[7]}}, key};
        return {pc4, r1, r2, imm, rs, rt, rd, key[5:0]};
    endfunction

    function automatic logic [DATA_BITS-1:0] ex_data();
        return {bus.ex_pc_plus4, bus.ex_rdata1, bus.ex_rdata2, bus.ex_imm,
                bus.ex_rs, bus.ex_rt, bus.ex_rd, bus.ex_funct};
    endfunction

    function automatic logic [8:0] ex_ctrl();
        return {bus.ex_RegDst, bus.ex_Branch, bus.ex_MemRead, bus.ex_MemtoReg,
                bus.ex_MemWrite, bus.ex_ALUsrc, bus.ex_RegWrite, bus.ex_ALUop};
    endfunction

    // Builds a non-hold vector. The captured data equals the driven data.
    function automatic vec_t mk(input logic vld, input logic [8:0] ctrl, input logic [4:0] rs,
                                input logic [4:0] rt, input logic [4:0] rd, input logic [7:0] key,
                                input logic fl, input logic ho, input logic es, input logic ev,
                                input logic [8:0] ec, input logic [8:0] m, input logic cd);
        vec_t v;
        v.vld = vld;  v.ctrl = ctrl; v.rs = rs; v.rt = rt; v.rd = rd; v.key = key;
        v.flush = fl; v.hold = ho;   v.exp_stall = es; v.exp_vld = ev;
        v.exp_ctrl = ec; v.mask = m; v.chk_data = cd;
        v.exp_rs = rs; v.exp_rt = rt; v.exp_rd = rd; v.exp_key = key;
        return v;
    endfunction

    // Builds a hold vector. EX must keep whatever the previous entry expected.
    function automatic vec_t mkh(input vec_t p, input logic vld, input logic [8:0] ctrl,
                                 input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                                 input logic [7:0] key);
        vec_t v;
        v = p;
        v.vld = vld; v.ctrl = ctrl; v.rs = rs; v.rt = rt; v.rd = rd; v.key = key;
        v.flush = 1'b0; v.hold = 1'b1; v.exp_stall = 1'b0;
        return v;
    endfunction

    task automatic chk(input string name, input logic [DATA_BITS-1:0] act,
                       input logic [DATA_BITS-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic vld, input logic [8:0] c, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [4:0] rd, input logic [7:0] key,
                         input logic fl, input logic ho);
        bus.id_valid = vld;
        {bus.id_RegDst, bus.id_Branch, bus.id_MemRead, bus.id_MemtoReg,
         bus.id_MemWrite, bus.id_ALUsrc, bus.id_RegWrite, bus.id_ALUop} = c;
        {bus.id_pc_plus4, bus.id_rdata1, bus.id_rdata2, bus.id_imm,
         bus.id_rs, bus.id_rt, bus.id_rd, bus.id_funct} = mk_data(rs, rt, rd, key);
        bus.flush = fl;
        bus.hold  = ho;
    endtask

    task automatic run_vec(input int idx);
        vec_t v;
        exp_t e;
        v = tbl[idx];
        @(negedge clk);
        drive(v.vld, v.ctrl, v.rs, v.rt, v.rd, v.key, v.flush, v.hold);
        #1;
        chk($sformatf("v%0d stall_out", idx), bus.stall_out, v.exp_stall);
        e.idx  = idx;
        e.vld  = v.exp_vld;
        e.ctrl = v.exp_ctrl;
        e.mask = v.mask;
        e.chk  = v.chk_data;
        e.data = mk_data(v.exp_rs, v.exp_rt, v.exp_rd, v.exp_key);
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL v%0d scoreboard: got empty queue expected an entry", idx);
        end else begin
            e = sb.pop_front();
            chk($sformatf("v%0d ex_valid", e.idx), bus.ex_valid, e.vld);
            chk($sformatf("v%0d ex_ctrl", e.idx), ex_ctrl() & e.mask, e.ctrl & e.mask);
            if (e.chk) chk($sformatf("v%0d ex_data", e.idx), ex_data(), e.data);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish before 100000");
        $fatal(1, "bench timeout");
    end

    initial begin
        //            vld ctrl   rs  rt  rd  key    fl hd  stl vld exp_ctrl mask   data
        tbl[0]  = mk(1, C_R,    2,  3,  4,  8'h11, 0, 0,  0,  1,  C_R,    M_ALL, 1); // R passthrough
        tbl[1]  = mk(1, C_LW,   1,  5,  0,  8'h22, 0, 0,  0,  1,  C_LW,   M_ALL, 1);
        tbl[2]  = mk(1, C_R,    5,  6,  7,  8'h33, 0, 0,  1,  0,  C_NOP,  M_ALL, 1); // load-use on rs
        tbl[3]  = mk(1, C_R,    5,  6,  7,  8'h33, 0, 0,  0,  1,  C_R,    M_ALL, 1); // single bubble only
        tbl[4]  = mk(1, C_LW,   0,  0,  0,  8'h44, 0, 0,  0,  1,  C_LW,   M_ALL, 1);
        tbl[5]  = mk(1, C_R,    0,  0,  8,  8'h55, 0, 0,  0,  1,  C_R,    M_ALL, 1); // r0 exempt
        tbl[6]  = mk(1, C_LW,   1,  9,  0,  8'h66, 0, 0,  0,  1,  C_LW,   M_ALL, 1);
        tbl[7]  = mk(1, C_ADDI, 2,  9,  0,  8'h77, 0, 0,  0,  1,  C_ADDI, M_ALL, 1); // addi rt not read
        tbl[8]  = mk(1, C_LW,   1,  10, 0,  8'h88, 0, 0,  0,  1,  C_LW,   M_ALL, 1);
        tbl[9]  = mk(1, C_SW,   3,  10, 0,  8'h99, 0, 0,  1,  0,  C_NOP,  M_ALL, 1); // sw reads rt
        tbl[10] = mk(1, C_SW,   3,  10, 0,  8'h99, 0, 0,  0,  1,  C_SW,   M_SW,  1);
        tbl[11] = mk(1, C_LW,   1,  11, 0,  8'hA1, 0, 0,  0,  1,  C_LW,   M_ALL, 1);
        tbl[12] = mk(1, C_BNE,  4,  11, 0,  8'hA2, 0, 0,  1,  0,  C_NOP,  M_ALL, 1); // bne reads rt
        tbl[13] = mk(1, C_BNE,  4,  11, 0,  8'hA2, 0, 0,  0,  1,  C_BNE,  M_BNE, 1);
        tbl[14] = mk(0, C_R,    1,  2,  12, 8'hA3, 0, 0,  0,  0,  C_NOP,  M_ALL, 1); // invalid slot
        tbl[15] = mk(1, C_LW,   1,  13, 0,  8'hA4, 0, 0,  0,  1,  C_LW,   M_ALL, 1);
        tbl[16] = mk(0, C_R,    13, 2,  3,  8'hA5, 0, 0,  0,  0,  C_NOP,  M_ALL, 1); // no hz if ID invalid
        tbl[17] = mk(1, C_NOP,  0,  0,  0,  8'h00, 0, 0,  0,  1,  C_NOP,  M_ALL, 1); // NOP is valid
        tbl[18] = mk(1, C_R,    1,  2,  3,  8'hA6, 1, 0,  0,  0,  C_NOP,  M_ALL, 0); // flush
        tbl[19] = mk(1, C_LW,   1,  14, 0,  8'hB1, 0, 0,  0,  1,  C_LW,   M_ALL, 1);
        tbl[20] = mk(1, C_R,    14, 2,  3,  8'hB2, 1, 1,  0,  0,  C_NOP,  M_ALL, 0); // flush+hold+hz
        tbl[21] = mk(1, C_LW,   1,  16, 0,  8'hB3, 0, 0,  0,  1,  C_LW,   M_ALL, 1);
        tbl[22] = mkh(tbl[21], 1, C_R, 16, 2, 3, 8'hB4);                             // hold + hz, 3 cycles
        tbl[23] = mkh(tbl[22], 1, C_R, 16, 2, 3, 8'hB4);
        tbl[24] = mkh(tbl[23], 1, C_R, 16, 2, 3, 8'hB4);
        tbl[25] = mk(1, C_R,    16, 2,  3,  8'hB4, 0, 0,  1,  0,  C_NOP,  M_ALL, 1); // bubble after release
        tbl[26] = mk(1, C_R,    16, 2,  3,  8'hB4, 0, 0,  0,  1,  C_R,    M_ALL, 1);
        tbl[27] = mk(1, C_LW,   1,  17, 0,  8'hC1, 0, 0,  0,  1,  C_LW,   M_ALL, 1);
        tbl[28] = mk(1, C_LW,   1,  18, 0,  8'hC2, 0, 0,  0,  1,  C_LW,   M_ALL, 1);
        tbl[29] = mk(1, C_R,    18, 2,  3,  8'hC3, 0, 0,  1,  0,  C_NOP,  M_ALL, 1);
        tbl[30] = mk(1, C_R,    18, 2,  3,  8'hC3, 0, 0,  0,  1,  C_R,    M_ALL, 1);
        tbl[31] = mk(1, C_LW,   1,  19, 0,  8'hC4, 0, 0,  0,  1,  C_LW,   M_ALL, 1);
        tbl[32] = mk(1, C_SW,   0,  19, 0,  8'hC5, 0, 0,  1,  0,  C_NOP,  M_ALL, 1);
        tbl[33] = mk(1, C_SW,   0,  19, 0,  8'hC5, 0, 0,  0,  1,  C_SW,   M_SW,  1);
        tbl[34] = mk(1, C_R,    1,  2,  3,  8'hC6, 1, 0,  0,  0,  C_NOP,  M_ALL, 0); // counted flush
        tbl[35] = mk(0, C_R,    1,  2,  3,  8'hC7, 1, 0,  0,  0,  C_NOP,  M_ALL, 0); // not counted

        // Power-on reset
        rst_n = 1'b0;
        drive(0, C_NOP, 0, 0, 0, 8'h00, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset ex_valid", bus.ex_valid, 1'b0);
        chk("reset ex_ctrl", ex_ctrl(), '0);
        chk("reset ex_data", ex_data(), '0);
        chk("reset stall_out", bus.stall_out, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < N_A; i++) run_vec(i);
`ifdef ID_EX_PERF_CNT_EN
        chk("bubble_cnt main", bubble_cnt, 32'd4);
        chk("flush_cnt main", flush_cnt, 32'd2);
`endif

        // Mid-cycle reset while a load-use stall is pending
        run_vec(I_PRE);
        @(negedge clk);
        drive(1, C_R, 17, 2, 3, 8'hC9, 0, 0);
        #1;
        chk("pre-reset stall_out", bus.stall_out, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async reset ex_valid", bus.ex_valid, 1'b0);
        chk("async reset ex_RegWrite", bus.ex_RegWrite, 1'b0);
        chk("async reset ex_ctrl", ex_ctrl(), '0);
        chk("async reset ex_data", ex_data(), '0);
        chk("async reset stall_out", bus.stall_out, 1'b0);
`ifdef ID_EX_PERF_CNT_EN
        chk("async reset bubble_cnt", bubble_cnt, '0);
        chk("async reset flush_cnt", flush_cnt, '0);
`endif
        @(posedge clk);
        #1;
        chk("reset held ex_valid", bus.ex_valid, 1'b0);
        chk("reset held ex_data", ex_data(), '0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, C_NOP, 0, 0, 0, 8'h00, 0, 0);

        for (int i = I_PRE + 1; i < N_VEC; i++) run_vec(i);
`ifdef ID_EX_PERF_CNT_EN
        chk("bubble_cnt post-reset", bubble_cnt, 32'd2);
        chk("flush_cnt post-reset", flush_cnt, 32'd1);
`endif

        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard drain: got %0d left expected 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register of the 5-stage MIPS pipeline. Sits directly downstream of the decode control unit: it captures that unit's eight control outputs, together with the register-file operands, the sign-extended immediate and the register specifiers.
- Contains load-use hazard detection. It inserts bubbles into EX and drives the stall that freezes the PC and the IF/ID register.
- Accepts a branch-resolution flush and a downstream hold.

Parameters:
- DATA_W, 32, width of operand, immediate and PC fields.
- REG_AW, 5, register specifier width.

Ports:
- clk  in  1  pipeline clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  ID slot holds a real instruction.
- id_pc_plus4  in  DATA_W  PC+4 of ID instruction.
- id_rdata1, id_rdata2  in  DATA_W  register-file read data (rs, rt).
- id_imm  in  DATA_W  sign-extended immediate.
- id_rs, id_rt, id_rd  in  REG_AW  register specifiers.
- id_funct  in  6  funct field.
- id_RegDst, id_Branch, id_MemRead, id_MemtoReg, id_MemWrite, id_ALUsrc, id_RegWrite  in  1 each  decode control.
- id_ALUop  in  2  decode ALU op class.
- flush  in  1  branch taken, resolved downstream; squash ID instruction.
- hold  in  1  downstream not ready; freeze ID/EX contents.
- ex_* (one per id_* input above, same widths)  out  registered copies.
- ex_valid  out  1  EX slot holds a real instruction.
- stall_out  out  1  combinational; freeze PC and IF/ID.

Behaviour:
- Reset (rst_n low, asynchronous): every ex_* output = 0 and ex_valid = 0; registers hold 0 while rst_n is low. stall_out evaluates to 0 because ex_valid = 0. The first capture happens on the first rising clk edge after rst_n deasserts.
- Load-use hazard, combinational:
  - hz = ex_valid & ex_MemRead & id_valid & (ex_rt != 0) & ((ex_rt == id_rs) | ((ex_rt == id_rt) & (~id_ALUsrc | id_MemWrite))).
  - The rt comparison applies only when ID reads rt: R-format, bne and sw.
  - stall_out = hz & ~flush & ~hold.
- Per rising edge, priority high to low:
  - 1. flush: ex_valid <= 0 and all eight control outputs <= 0. Data fields are don't-care. flush overrides hold.
  - 2. hold: all registers keep their value.
  - 3. hz: bubble. ex_valid <= 0 and control <= 0. Data fields load the ID values; they are harmless.
  - 4. Otherwise: all ex_* <= id_* and ex_valid <= id_valid.
- Invalid ID slot (id_valid = 0, no flush/hold): control loads 0 regardless of the id_* control inputs.
- Latency: exactly 1 cycle from ID to EX. A single load-use produces exactly one bubble, because next cycle ex_MemRead = 0 and the hazard clears.
- Don't-care decode bits: control bits that decode drives as X (sw RegDst/MemtoReg, bne RegDst) pass through unchanged.
  - RTL must not rely on them.
  - The bench must not check them.
- Zero-funct R-format (NOP) arrives with all control 0 and is treated like any instruction; ex_valid follows id_valid.
- Reset mid-operation: state clears immediately. A pending hold, stall or flush is discarded.

Optional Feature:
- Macro ID_EX_PERF_CNT_EN.
- Defined: adds outputs bubble_cnt[31:0] (increments on each hz bubble insertion) and flush_cnt[31:0] (increments on each flush edge that squashes a valid instruction, id_valid = 1).
  - Both counters wrap at 2^32, reset to 0 asynchronously, and do not increment while hold is high unless flush is also asserted.
- Undefined: these ports and counters are absent. All other behaviour is identical.

Test Plan:
- Reset: assert rst_n = 0 mid-cycle with ex_RegWrite = 1 -> all ex_* = 0, ex_valid = 0 and stall_out = 0 immediately, without waiting for a clock edge.
- R-format passthrough: id_rs = 2, id_rt = 3, id_rd = 4, ALUop = 10, RegDst = 1, RegWrite = 1, id_rdata1 = 0x11 -> next edge ex_rd = 4, ex_ALUop = 10, ex_rdata1 = 0x11, ex_valid = 1, stall_out = 0.
- Load-use: lw with rt = 5 in EX; ID holds add with rs = 5 -> stall_out = 1; next edge ex_valid = 0 and controls are 0; the following cycle the add enters EX with stall_out = 0.
- Register-0 exemption: lw rt = 0 in EX; ID add rs = 0 -> stall_out = 0, no bubble.
- Flush vs hold vs hazard: flush = 1, hold = 1 and hz true together -> stall_out = 0; next edge ex_valid = 0. With hold = 1 only, ex_* are unchanged for 3 cycles.
- With ID_EX_PERF_CNT_EN: two load-use bubbles and one flush of a valid instruction -> bubble_cnt = 2, flush_cnt = 1.
